// File: rtl/mem_request_unit.sv
// Memory request sequencer between the ALU and the memory system: fetch/data handshake,
// PC-advance pulse, misaligned-address and timeout detection, and sticky halt.
module mem_request_unit #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ihit,
  input  logic              dhit,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              halt_in,
  input  logic [ADDR_W-1:0] alu_result,
  input  logic [DATA_W-1:0] store_data,
  input  logic [DATA_W-1:0] dload,
  output logic              imemREN,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [ADDR_W-1:0] dmemaddr,
  output logic [DATA_W-1:0] dmemstore,
  output logic [DATA_W-1:0] load_q,
  output logic              pc_en,
  output logic              halt_out,
  output logic [1:0]        fault
);

  localparam logic [1:0] FaultNone     = 2'b00;
  localparam logic [1:0] FaultMisalign = 2'b01;
  localparam logic [1:0] FaultTimeout  = 2'b10;

  // Counter value during the last DATA cycle that may still see dhit before faulting.
  localparam logic [15:0] WaitLast = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    StFetch = 2'b00,
    StData  = 2'b01,
    StHalt  = 2'b10
  } state_e;

  state_e            state_q;
  logic              is_write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] store_q;
  logic [DATA_W-1:0] load_data_q;
  logic              halt_q;
  logic [1:0]        fault_q;
  logic [15:0]       wait_cnt_q;

  logic mem_access;
  assign mem_access = mem_read | mem_write;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= StFetch;
      is_write_q  <= 1'b0;
      addr_q      <= '0;
      store_q     <= '0;
      load_data_q <= '0;
      halt_q      <= 1'b0;
      fault_q     <= FaultNone;
      wait_cnt_q  <= '0;
    end else begin
      unique case (state_q)
        StFetch: begin
          if (ihit) begin
            if (halt_in) begin
              state_q <= StHalt;
              halt_q  <= 1'b1;
            end else if (mem_access) begin
              if (alu_result[1:0] != 2'b00) begin
                if (fault_q == FaultNone) fault_q <= FaultMisalign;
                state_q <= StHalt;
                halt_q  <= 1'b1;
              end else begin
                addr_q     <= alu_result;
                store_q    <= store_data;
                is_write_q <= mem_write;
                wait_cnt_q <= '0;
                state_q    <= StData;
              end
            end
          end
        end
        StData: begin
          if (dhit) begin
            if (!is_write_q) load_data_q <= dload;
            state_q <= StFetch;
          end else begin
            wait_cnt_q <= wait_cnt_q + 16'd1;
            if (wait_cnt_q == WaitLast) begin
              if (fault_q == FaultNone) fault_q <= FaultTimeout;
              state_q <= StHalt;
              halt_q  <= 1'b1;
            end
          end
        end
        StHalt: begin
          halt_q <= 1'b1;
        end
        default: begin
          state_q <= StHalt;
          halt_q  <= 1'b1;
        end
      endcase
    end
  end

  // imemREN is held low while reset is asserted and rises once it is released.
  assign imemREN   = nRST && (state_q == StFetch);
  assign dmemREN   = (state_q == StData) && !is_write_q;
  assign dmemWEN   = (state_q == StData) && is_write_q;
  assign dmemaddr  = addr_q;
  assign dmemstore = store_q;
  assign load_q    = load_data_q;
  assign halt_out  = halt_q;
  assign fault     = fault_q;

  always_comb begin
    pc_en = 1'b0;
    unique case (state_q)
      StFetch: pc_en = ihit && !halt_in && !mem_access;
      StData:  pc_en = dhit;
      default: pc_en = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_mem_request_unit.sv
// Directed bench for mem_request_unit: default-TIMEOUT instance plus a TIMEOUT=4 instance
// sharing the same stimulus.
module tb_mem_request_unit;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        ihit = 1'b0, dhit = 1'b0, mem_read = 1'b0, mem_write = 1'b0, halt_in = 1'b0;
  logic [31:0] alu_result = '0, store_data = '0, dload = '0;

  logic        imemREN, dmemREN, dmemWEN, pc_en, halt_out;
  logic [31:0] dmemaddr, dmemstore, load_q;
  logic [1:0]  fault;

  logic        t4_imemREN, t4_dmemREN, t4_dmemWEN, t4_pc_en, t4_halt_out;
  logic [31:0] t4_dmemaddr, t4_dmemstore, t4_load_q;
  logic [1:0]  t4_fault;

  int n_pass = 0;
  int n_total = 0;

  always #5 CLK = ~CLK;

  mem_request_unit dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mem_read(mem_read),
    .mem_write(mem_write), .halt_in(halt_in), .alu_result(alu_result),
    .store_data(store_data), .dload(dload), .imemREN(imemREN), .dmemREN(dmemREN),
    .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore), .load_q(load_q),
    .pc_en(pc_en), .halt_out(halt_out), .fault(fault)
  );

  mem_request_unit #(.TIMEOUT(4)) dut4 (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mem_read(mem_read),
    .mem_write(mem_write), .halt_in(halt_in), .alu_result(alu_result),
    .store_data(store_data), .dload(dload), .imemREN(t4_imemREN), .dmemREN(t4_dmemREN),
    .dmemWEN(t4_dmemWEN), .dmemaddr(t4_dmemaddr), .dmemstore(t4_dmemstore),
    .load_q(t4_load_q), .pc_en(t4_pc_en), .halt_out(t4_halt_out), .fault(t4_fault)
  );

  task automatic idle_inputs();
    ihit = 0; dhit = 0; mem_read = 0; mem_write = 0; halt_in = 0;
    alu_result = '0; store_data = '0; dload = '0;
  endtask

  task automatic test_reset();
    @(negedge CLK);
    idle_inputs();
    nRST = 0;
    #1;
    n_total++; if ({dmemREN, dmemWEN} !== 2'b00) $display("FAIL rst_req got=%b exp=00", {dmemREN, dmemWEN}); else n_pass++;
    n_total++; if (pc_en !== 1'b0) $display("FAIL rst_pc_en got=%b exp=0", pc_en); else n_pass++;
    n_total++; if (halt_out !== 1'b0) $display("FAIL rst_halt got=%b exp=0", halt_out); else n_pass++;
    n_total++; if (fault !== 2'b00) $display("FAIL rst_fault got=%b exp=00", fault); else n_pass++;
    n_total++; if ({dmemaddr, dmemstore, load_q} !== 96'd0) $display("FAIL rst_regs got=%h exp=0", {dmemaddr, dmemstore, load_q}); else n_pass++;
    n_total++; if (t4_fault !== 2'b00) $display("FAIL rst_t4_fault got=%b exp=00", t4_fault); else n_pass++;
    @(negedge CLK);
    nRST = 1;
    #1;
    n_total++; if (imemREN !== 1'b1) $display("FAIL rst_imemREN got=%b exp=1", imemREN); else n_pass++;
  endtask

  task automatic test_no_access();
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      ihit = 1;
      #1;
      n_total++; if (pc_en !== 1'b1) $display("FAIL noacc_pc_en[%0d] got=%b exp=1", i, pc_en); else n_pass++;
      n_total++; if ({imemREN, dmemREN, dmemWEN} !== 3'b100) $display("FAIL noacc_req[%0d] got=%b exp=100", i, {imemREN, dmemREN, dmemWEN}); else n_pass++;
      n_total++; if (fault !== 2'b00) $display("FAIL noacc_fault[%0d] got=%b exp=00", i, fault); else n_pass++;
    end
  endtask

  task automatic test_load();
    @(negedge CLK);
    ihit = 1; mem_read = 1; alu_result = 32'h0000_0104;
    #1;
    n_total++; if (pc_en !== 1'b0) $display("FAIL ld_issue_pc_en got=%b exp=0", pc_en); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      idle_inputs();
      alu_result = 32'h0000_0F00;
      ihit = (i == 1);
      if (i == 3) begin dhit = 1; dload = 32'hDEAD_BEEF; end
      #1;
      n_total++; if ({imemREN, dmemREN, dmemWEN} !== 3'b010) $display("FAIL ld_req[%0d] got=%b exp=010", i, {imemREN, dmemREN, dmemWEN}); else n_pass++;
      n_total++; if (dmemaddr !== 32'h104) $display("FAIL ld_addr[%0d] got=%h exp=104", i, dmemaddr); else n_pass++;
      n_total++; if (pc_en !== (i == 3)) $display("FAIL ld_pc_en[%0d] got=%b exp=%b", i, pc_en, i == 3); else n_pass++;
    end
    @(negedge CLK);
    idle_inputs();
    #1;
    n_total++; if (load_q !== 32'hDEAD_BEEF) $display("FAIL ld_load_q got=%h exp=deadbeef", load_q); else n_pass++;
    n_total++; if ({imemREN, dmemREN, pc_en} !== 3'b100) $display("FAIL ld_done got=%b exp=100", {imemREN, dmemREN, pc_en}); else n_pass++;
  endtask

  task automatic test_store();
    @(negedge CLK);
    ihit = 1; mem_write = 1; alu_result = 32'h200; store_data = 32'h1234_5678;
    #1;
    n_total++; if (pc_en !== 1'b0) $display("FAIL st_issue_pc_en got=%b exp=0", pc_en); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      idle_inputs();
      alu_result = 32'h0000_FFF0; store_data = 32'hAAAA_5555; dload = 32'h0BAD_0BAD;
      dhit = (i == 2);
      #1;
      n_total++; if ({dmemREN, dmemWEN} !== 2'b01) $display("FAIL st_req[%0d] got=%b exp=01", i, {dmemREN, dmemWEN}); else n_pass++;
      n_total++; if ({dmemaddr, dmemstore} !== {32'h200, 32'h1234_5678}) $display("FAIL st_hold[%0d] got=%h exp=0000020012345678", i, {dmemaddr, dmemstore}); else n_pass++;
      n_total++; if (pc_en !== (i == 2)) $display("FAIL st_pc_en[%0d] got=%b exp=%b", i, pc_en, i == 2); else n_pass++;
    end
    @(negedge CLK);
    idle_inputs();
    #1;
    n_total++; if ({imemREN, dmemWEN} !== 2'b10) $display("FAIL st_done got=%b exp=10", {imemREN, dmemWEN}); else n_pass++;
    n_total++; if (load_q !== 32'hDEAD_BEEF) $display("FAIL st_load_q got=%h exp=deadbeef", load_q); else n_pass++;
    n_total++; if (dmemstore !== 32'h1234_5678) $display("FAIL st_fetch_hold got=%h exp=12345678", dmemstore); else n_pass++;
  endtask

  task automatic test_read_write_both();
    @(negedge CLK);
    ihit = 1; mem_read = 1; mem_write = 1; alu_result = 32'h300; store_data = 32'h5;
    @(negedge CLK);
    idle_inputs();
    dhit = 1; dload = 32'h1111_1111;
    #1;
    n_total++; if ({dmemREN, dmemWEN} !== 2'b01) $display("FAIL rw_req got=%b exp=01", {dmemREN, dmemWEN}); else n_pass++;
    @(negedge CLK);
    idle_inputs();
    #1;
    n_total++; if (load_q !== 32'hDEAD_BEEF) $display("FAIL rw_load_q got=%h exp=deadbeef", load_q); else n_pass++;
  endtask

  task automatic test_misaligned();
    @(negedge CLK);
    ihit = 1; mem_read = 1; alu_result = 32'h0000_0102;
    #1;
    n_total++; if (pc_en !== 1'b0) $display("FAIL mis_pc_en got=%b exp=0", pc_en); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      ihit = 1; mem_read = 1; dhit = 1; alu_result = 32'h0000_0400;
      #1;
      n_total++; if ({imemREN, dmemREN, dmemWEN, pc_en} !== 4'b0000) $display("FAIL mis_quiet[%0d] got=%b exp=0000", i, {imemREN, dmemREN, dmemWEN, pc_en}); else n_pass++;
      n_total++; if ({halt_out, fault} !== 3'b101) $display("FAIL mis_fault[%0d] got=%b exp=101", i, {halt_out, fault}); else n_pass++;
      n_total++; if (dmemaddr !== 32'h300) $display("FAIL mis_addr[%0d] got=%h exp=300", i, dmemaddr); else n_pass++;
    end
  endtask

  task automatic test_timeout(input bit late_hit);
    test_reset();
    @(negedge CLK);
    ihit = 1; mem_write = 1; alu_result = 32'h40; store_data = 32'h77;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      idle_inputs();
      dhit = late_hit && (i == 3);
      #1;
      n_total++; if (t4_dmemWEN !== 1'b1) $display("FAIL to%0d_wen[%0d] got=%b exp=1", late_hit, i, t4_dmemWEN); else n_pass++;
      n_total++; if (t4_pc_en !== dhit) $display("FAIL to%0d_pc_en[%0d] got=%b exp=%b", late_hit, i, t4_pc_en, dhit); else n_pass++;
    end
    @(negedge CLK);
    idle_inputs();
    dhit = 1;
    #1;
    if (late_hit) begin
      n_total++; if ({t4_halt_out, t4_fault} !== 3'b000) $display("FAIL to1_fault got=%b exp=000", {t4_halt_out, t4_fault}); else n_pass++;
      n_total++; if ({t4_imemREN, t4_dmemWEN} !== 2'b10) $display("FAIL to1_req got=%b exp=10", {t4_imemREN, t4_dmemWEN}); else n_pass++;
    end else begin
      n_total++; if ({t4_halt_out, t4_fault} !== 3'b110) $display("FAIL to0_fault got=%b exp=110", {t4_halt_out, t4_fault}); else n_pass++;
      n_total++; if ({t4_imemREN, t4_dmemREN, t4_dmemWEN, t4_pc_en} !== 4'b0000) $display("FAIL to0_req got=%b exp=0000", {t4_imemREN, t4_dmemREN, t4_dmemWEN, t4_pc_en}); else n_pass++;
      n_total++; if ({dmemWEN, fault} !== 3'b100) $display("FAIL to0_default got=%b exp=100", {dmemWEN, fault}); else n_pass++;
    end
  endtask

  task automatic test_halt();
    test_reset();
    @(negedge CLK);
    ihit = 1; halt_in = 1; mem_write = 1; alu_result = 32'h80; store_data = 32'h99;
    #1;
    n_total++; if (pc_en !== 1'b0) $display("FAIL halt_pc_en got=%b exp=0", pc_en); else n_pass++;
    @(negedge CLK);
    idle_inputs();
    ihit = 1;
    #1;
    n_total++; if ({imemREN, dmemWEN, pc_en} !== 3'b000) $display("FAIL halt_req got=%b exp=000", {imemREN, dmemWEN, pc_en}); else n_pass++;
    n_total++; if ({halt_out, fault} !== 3'b100) $display("FAIL halt_flag got=%b exp=100", {halt_out, fault}); else n_pass++;
    n_total++; if ({dmemaddr, dmemstore} !== 64'd0) $display("FAIL halt_regs got=%h exp=0", {dmemaddr, dmemstore}); else n_pass++;
  endtask

  task automatic test_async_reset();
    test_reset();
    @(negedge CLK);
    ihit = 1; mem_read = 1; alu_result = 32'h104;
    @(negedge CLK);
    idle_inputs();
    #1;
    n_total++; if ({dmemREN, dmemaddr} !== {1'b1, 32'h104}) $display("FAIL ar_before got=%h exp=100000104", {dmemREN, dmemaddr}); else n_pass++;
    #1;
    dhit = 1; dload = 32'hCAFE_F00D;
    nRST = 0;
    #1;
    n_total++; if ({dmemREN, dmemWEN, pc_en} !== 3'b000) $display("FAIL ar_drop got=%b exp=000", {dmemREN, dmemWEN, pc_en}); else n_pass++;
    n_total++; if ({dmemaddr, load_q} !== 64'd0) $display("FAIL ar_regs got=%h exp=0", {dmemaddr, load_q}); else n_pass++;
    @(negedge CLK);
    idle_inputs();
    nRST = 1;
    #1;
    n_total++; if ({imemREN, pc_en, load_q} !== {2'b10, 32'd0}) $display("FAIL ar_after got=%h exp=200000000", {imemREN, pc_en, load_q}); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_no_access();
    test_load();
    test_store();
    test_read_write_both();
    test_misaligned();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_halt();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
